hazard_scoreboard: RTL
======================

Name: hazard_scoreboard

Overview:
- Parametrised successor to the pipeline hazard logic.
- Tracks in-flight register writes in a DEPTH-entry shift scoreboard (stage 1 = EX … stage DEPTH = last stage before regfile write).
- Generates load-use and branch-operand stalls, forwarding selects, branch/jump redirect and flush.
- Freezes everything while data memory waits.
- Sits beside the ID stage; drives the IF/ID enable, ID/EX bubble and the operand muxes.

Parameters:
REG_W, 5, register index width (2**REG_W registers; index 0 never written)
DEPTH, 3, scoreboard stages tracked after ID (≥2)
LOAD_LAT, 1, stages after EX before load data is forwardable (1 ≤ LOAD_LAT < DEPTH)
FORWARD, 1, 1 = forward from scoreboard stages; 0 = stall until producer leaves scoreboard
FWD_W, $clog2(DEPTH+1), forwarding select width

Ports:
CLK  in  1  clock, rising edge
RST  in  1  reset, asynchronous, active-high
advance  in  1  pipeline enable (ihit and no global freeze)
dmem_wait  in  1  MEM stage waiting for dhit
id_valid  in  1  ID holds a real instruction
id_rs, id_rt  in  REG_W  source registers
id_use_rs, id_use_rt  in  1  source actually read
id_dest  in  REG_W  destination
id_wen  in  1  instruction writes id_dest
id_load  in  1  instruction is LW/LL
id_br  in  2  00 none, 01 BEQ, 10 BNE, 11 reserved (treated as none)
id_jump  in  1  J/JAL/JR
id_equal  in  1  ID comparator result on forwarded operands
stall  out  1  hold IF/ID, inject bubble into EX
hold  out  1  freeze entire pipeline
branch, jump, flush  out  1  redirect PC / squash IF/ID
fwd_a, fwd_b  out  FWD_W  0 = regfile, k = forward from stage k

Behaviour:
- Entry k = {v, dest, ld}; v forced 0 when dest==0.
- Reset (async, RST=1): all v=0; FSM=RUN; every output 0.

FSM:
- RUN→HOLD when dmem_wait=1.
- HOLD→RUN on the first cycle dmem_wait=0.
- hold = (state==HOLD) | dmem_wait, combinational.
- RST mid-HOLD → RUN, scoreboard cleared.

Scoreboard update, on the clock edge:
- if hold or !advance: all entries keep their value;
- else if stall: sb[1] ← invalid, sb[k+1] ← sb[k];
- else: sb[1] ← {id_valid&id_wen, id_dest, id_load}, sb[k+1] ← sb[k]; sb[DEPTH] retires.

Match:
- For each used source, the youngest k (smallest) with sb[k].v & sb[k].dest == src.
- Youngest wins; older matches are ignored.

stall (combinational, 0 when !id_valid) if any source match at stage k with:
- FORWARD=1: sb[k].ld & k ≤ LOAD_LAT;
- FORWARD=0: any k;
- branch (id_br≠0) sources additionally: k==1, or sb[k].ld & k ≤ LOAD_LAT+1.

Forwarding:
- fwd_x = k of the youngest match when FORWARD=1 & !stall, else 0.
- Unused source → 0.

Branch/jump/flush:
- branch = !stall & id_valid & ((id_br==01 & id_equal) | (id_br==10 & !id_equal)).
- jump = !stall & id_valid & id_jump.
- flush = (branch|jump) & advance & !hold.

Simultaneous events:
- hold dominates stall: scoreboard frozen, flush 0, stall still reported.
- stall with !advance: no bubble, no shift.
- Register 0 never stalls or forwards.

Latency: all outputs combinational from inputs plus registered scoreboard; zero-cycle.

Optional Feature:
HAZARD_STATS_EN:
- Defined: adds outputs stall_cnt[31:0], hold_cnt[31:0], flush_cnt[31:0].
- Counters increment on cycles where stall&advance&!hold, hold, and flush respectively.
- Counters saturate at all-ones and reset to 0.
- Undefined: ports and counters are absent; behaviour is otherwise identical.

Decomposition:
- Shared package cpu_types_pkg: sb_entry_t {v, dest, ld}, branch-type enum (BR_NONE, BR_EQ, BR_NE), FSM enum (HZ_RUN, HZ_HOLD).
- Interface hazard_if extended with the new signals.
- One sub-module, hazard_match: combinational youngest-match finder, instantiated once per source. Inputs: src, use, scoreboard array. Outputs: hit, stage index, ld.

Test Plan:
1. Load-use. LW r2 issued, next ADD r3,r2,r4, advance=1, FORWARD=1, LOAD_LAT=1 → stall=1 for exactly 1 cycle, bubble in sb[1]; next cycle fwd_a=2, stall=0.
2. ALU chain. ADD r5 then SUB r6,r5,r5 → stall=0, fwd_a=fwd_b=1; with FORWARD=0 → stall for 3 cycles (DEPTH), then fwd=0.
3. Branch. ADD r7 then BEQ r7,r8 with id_equal=1 → stall 1 cycle, then branch=1, flush=1; BNE with id_equal=1 → branch=0.
4. Memory freeze. dmem_wait=1 for 4 cycles during a load-use stall → hold=1, scoreboard unchanged, flush=0; after release, stall resolves as in scenario 1.
5. Zero register and youngest match. ADD r0 then use r0 → no stall, fwd=0. Two writers of r9 at stages 1 and 3 → fwd=1.
6. Async reset. RST asserted mid-HOLD between clock edges → outputs 0 immediately; FSM=RUN; scoreboard empty (with HAZARD_STATS_EN, counters=0).

Source files
------------

// File: rtl/cpu_types_pkg.sv
// cpu_types_pkg: types shared by the hazard unit and its helpers.
// Scoreboard entries carry a destination field wide enough for any supported
// register file (REG_W up to SB_DEST_W); narrower indices are zero-extended.
package cpu_types_pkg;

  localparam int SB_DEST_W = 8;

  typedef struct packed {
    logic                 v;
    logic [SB_DEST_W-1:0] dest;
    logic                 ld;
  } sb_entry_t;

  typedef enum logic [1:0] {
    BR_NONE = 2'b00,
    BR_EQ   = 2'b01,
    BR_NE   = 2'b10
  } br_type_e;

  typedef enum logic {
    HZ_RUN  = 1'b0,
    HZ_HOLD = 1'b1
  } hz_state_e;

endpackage

// File: rtl/hazard_if.sv
// hazard_if: signal bundle between ID-stage control and hazard_scoreboard.
// Optional statistics counters appear when HAZARD_STATS_EN is defined.
interface hazard_if #(
  parameter int REG_W = 5,
  parameter int FWD_W = 2
);
  logic             advance;
  logic             dmem_wait;
  logic             id_valid;
  logic [REG_W-1:0] id_rs;
  logic [REG_W-1:0] id_rt;
  logic             id_use_rs;
  logic             id_use_rt;
  logic [REG_W-1:0] id_dest;
  logic             id_wen;
  logic             id_load;
  logic [1:0]       id_br;
  logic             id_jump;
  logic             id_equal;
  logic             stall;
  logic             hold;
  logic             branch;
  logic             jump;
  logic             flush;
  logic [FWD_W-1:0] fwd_a;
  logic [FWD_W-1:0] fwd_b;
`ifdef HAZARD_STATS_EN
  logic [31:0]      stall_cnt;
  logic [31:0]      hold_cnt;
  logic [31:0]      flush_cnt;
`endif
endinterface

// File: rtl/hazard_match.sv
// hazard_match: finds the youngest scoreboard stage writing a given source
// register. Stage 1 is the youngest, so older matches are shadowed.
module hazard_match
  import cpu_types_pkg::*;
#(
  parameter int REG_W = 5,
  parameter int DEPTH = 3,
  parameter int FWD_W = $clog2(DEPTH + 1)
) (
  input  logic [REG_W-1:0] i_src,
  input  logic             i_use,
  input  sb_entry_t        i_sb [1:DEPTH],
  output logic             o_hit,
  output logic [FWD_W-1:0] o_stage,
  output logic             o_ld
);

  logic [SB_DEST_W-1:0] w_srcExt;

  assign w_srcExt = SB_DEST_W'(i_src);

  // Scan oldest to youngest so the last hit written is the youngest producer
  always_comb begin
    o_hit   = 1'b0;
    o_stage = '0;
    o_ld    = 1'b0;
    for (int k = DEPTH; k >= 1; k--) begin
      if (i_use && i_sb[k].v && (i_sb[k].dest == w_srcExt)) begin
        o_hit   = 1'b1;
        o_stage = FWD_W'(k);
        o_ld    = i_sb[k].ld;
      end
    end
  end

endmodule

// File: rtl/hazard_scoreboard.sv
// hazard_scoreboard: tracks in-flight register writes and produces stall,
// hold, forwarding selects and branch/jump redirect for the ID stage.
// Optional macro HAZARD_STATS_EN adds saturating stall/hold/flush counters.
module hazard_scoreboard
  import cpu_types_pkg::*;
#(
  parameter int REG_W    = 5,
  parameter int DEPTH    = 3,
  parameter int LOAD_LAT = 1,
  parameter int FORWARD  = 1,
  parameter int FWD_W    = $clog2(DEPTH + 1)
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             advance,
  input  logic             dmem_wait,
  input  logic             id_valid,
  input  logic [REG_W-1:0] id_rs,
  input  logic [REG_W-1:0] id_rt,
  input  logic             id_use_rs,
  input  logic             id_use_rt,
  input  logic [REG_W-1:0] id_dest,
  input  logic             id_wen,
  input  logic             id_load,
  input  logic [1:0]       id_br,
  input  logic             id_jump,
  input  logic             id_equal,
  output logic             stall,
  output logic             hold,
  output logic             branch,
  output logic             jump,
  output logic             flush,
  output logic [FWD_W-1:0] fwd_a,
  output logic [FWD_W-1:0] fwd_b
`ifdef HAZARD_STATS_EN
  ,
  output logic [31:0]      stall_cnt,
  output logic [31:0]      hold_cnt,
  output logic [31:0]      flush_cnt
`endif
);

  sb_entry_t        r_sb [1:DEPTH];
  hz_state_e        r_state;
  hz_state_e        w_nextState;
  sb_entry_t        w_newEntry;
  logic             w_hitA, w_hitB, w_ldA, w_ldB;
  logic [FWD_W-1:0] w_stageA, w_stageB;
  logic             w_isBr, w_stall, w_hold, w_branch, w_jump, w_flush;
  logic [FWD_W-1:0] w_fwdA, w_fwdB;

  // A source stalls when its producer cannot supply the value in time
  function automatic logic needStall(input logic hit, input logic [FWD_W-1:0] stg,
                                     input logic ld, input logic isBr);
    logic s;
    s = 1'b0;
    if (hit) begin
      if (FORWARD == 0) s = 1'b1;
      else if (ld && (stg <= FWD_W'(LOAD_LAT))) s = 1'b1;
      if (isBr && ((stg == FWD_W'(1)) || (ld && (stg <= FWD_W'(LOAD_LAT + 1))))) s = 1'b1;
    end
    return s;
  endfunction

  hazard_match #(.REG_W(REG_W), .DEPTH(DEPTH), .FWD_W(FWD_W)) u_matchA (
    .i_src(id_rs), .i_use(id_use_rs), .i_sb(r_sb),
    .o_hit(w_hitA), .o_stage(w_stageA), .o_ld(w_ldA)
  );

  hazard_match #(.REG_W(REG_W), .DEPTH(DEPTH), .FWD_W(FWD_W)) u_matchB (
    .i_src(id_rt), .i_use(id_use_rt), .i_sb(r_sb),
    .o_hit(w_hitB), .o_stage(w_stageB), .o_ld(w_ldB)
  );

  assign w_isBr    = (id_br == BR_EQ) || (id_br == BR_NE);
  assign w_stall   = id_valid & (needStall(w_hitA, w_stageA, w_ldA, w_isBr) |
                                 needStall(w_hitB, w_stageB, w_ldB, w_isBr));
  assign w_hold    = (r_state == HZ_HOLD) | dmem_wait;
  assign w_branch  = !w_stall & id_valid & (((id_br == BR_EQ) & id_equal) |
                                            ((id_br == BR_NE) & !id_equal));
  assign w_jump    = !w_stall & id_valid & id_jump;
  assign w_flush   = (w_branch | w_jump) & advance & !w_hold;
  assign w_fwdA    = ((FORWARD != 0) && !w_stall) ? w_stageA : '0;
  assign w_fwdB    = ((FORWARD != 0) && !w_stall) ? w_stageB : '0;

  assign w_newEntry.v    = id_valid & id_wen & (id_dest != '0);
  assign w_newEntry.dest = SB_DEST_W'(id_dest);
  assign w_newEntry.ld   = id_load;

  // Outputs read as zero for the whole time reset is asserted
  always_comb begin
    stall  = 1'b0;
    hold   = 1'b0;
    branch = 1'b0;
    jump   = 1'b0;
    flush  = 1'b0;
    fwd_a  = '0;
    fwd_b  = '0;
    if (!RST) begin
      stall  = w_stall;
      hold   = w_hold;
      branch = w_branch;
      jump   = w_jump;
      flush  = w_flush;
      fwd_a  = w_fwdA;
      fwd_b  = w_fwdB;
    end
  end

  // Freeze FSM: stay in HOLD while the data memory keeps waiting
  always_comb begin
    w_nextState = r_state;
    case (r_state)
      HZ_RUN:  if (dmem_wait)  w_nextState = HZ_HOLD;
      HZ_HOLD: if (!dmem_wait) w_nextState = HZ_RUN;
      default: w_nextState = HZ_RUN;
    endcase
  end

  // Freeze FSM state register
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) r_state <= HZ_RUN;
    else     r_state <= w_nextState;
  end

  // Scoreboard shifts only when the pipeline moves; a stall shifts in a bubble
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      for (int k = 1; k <= DEPTH; k++) r_sb[k] <= '0;
    end else if (!w_hold && advance) begin
      for (int k = DEPTH; k >= 2; k--) r_sb[k] <= r_sb[k-1];
      r_sb[1] <= w_stall ? sb_entry_t'('0) : w_newEntry;
    end
  end

`ifdef HAZARD_STATS_EN
  logic [31:0] r_stallCnt, r_holdCnt, r_flushCnt;

  // Saturating event counters for performance monitoring
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_stallCnt <= '0;
      r_holdCnt  <= '0;
      r_flushCnt <= '0;
    end else begin
      if (w_stall && advance && !w_hold && (r_stallCnt != '1)) r_stallCnt <= r_stallCnt + 32'd1;
      if (w_hold && (r_holdCnt != '1))                         r_holdCnt  <= r_holdCnt + 32'd1;
      if (w_flush && (r_flushCnt != '1))                       r_flushCnt <= r_flushCnt + 32'd1;
    end
  end

  assign stall_cnt = r_stallCnt;
  assign hold_cnt  = r_holdCnt;
  assign flush_cnt = r_flushCnt;
`endif

endmodule
